// File: rtl/c_block_drain_pkg.sv
// Shared gemm package: FSM state encoding for the C-block drain and the
// default mesh/interface constants that the drain and its address
// generator use as parameter defaults.
//
// Contents:
//   drain_state_e       - drain FSM states (IDLE, READ, CAPTURE, EMIT, DONE)
//   Def*                - default element width, mesh shape, address widths
//   idx_width()         - counter width for an index range 0..n-1 (min 1 bit)
package c_block_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } drain_state_e;

    localparam int unsigned DefOutDataWidth  = 32;
    localparam int unsigned DefMeshRow       = 4;
    localparam int unsigned DefMeshCol       = 4;
    localparam int unsigned DefAddrWidth     = 12;
    localparam int unsigned DefSizeAddrWidth = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/c_block_drain_addr_gen.sv
// c_drain_addr_gen: m/r/n loop counters and SRAM C block address for the
// C-block drain. Loop nesting is m (outer), r, n (inner); the column index c
// lives in the top because it advances per stream element, not per read.
//
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   load_i          - accepted start: register sizes, clear counters
//   M_size_i        - block rows to register on load_i
//   N_size_i        - block columns to register on load_i
//   advance_i       - one row fragment fully emitted: step n, then r, then m
//   r_o             - current row within the block
//   addr_o          - m*N + n truncated to AddrWidth
//   last_frag_o     - current fragment is the final one of the matrix
module c_drain_addr_gen
    import c_block_drain_pkg::*;
#(
    parameter int unsigned meshRow       = DefMeshRow,
    parameter int unsigned AddrWidth     = DefAddrWidth,
    parameter int unsigned SizeAddrWidth = DefSizeAddrWidth,
    parameter int unsigned RowIdxWidth   = idx_width(meshRow)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    input  logic                     advance_i,
    output logic [RowIdxWidth-1:0]   r_o,
    output logic [AddrWidth-1:0]     addr_o,
    output logic                     last_frag_o
);

    logic [SizeAddrWidth-1:0] m_size_q, m_size_d;
    logic [SizeAddrWidth-1:0] n_size_q, n_size_d;
    logic [SizeAddrWidth-1:0] m_q, m_d;
    logic [SizeAddrWidth-1:0] n_q, n_d;
    logic [RowIdxWidth-1:0]   r_q, r_d;
    logic                     m_last, n_last, r_last;

    assign m_last = (m_q == m_size_q - 1'b1);
    assign n_last = (n_q == n_size_q - 1'b1);
    assign r_last = (r_q == RowIdxWidth'(meshRow - 1));

    always_comb begin
        m_size_d = m_size_q;
        n_size_d = n_size_q;
        m_d      = m_q;
        n_d      = n_q;
        r_d      = r_q;
        if (load_i) begin
            m_size_d = M_size_i;
            n_size_d = N_size_i;
            m_d      = '0;
            n_d      = '0;
            r_d      = '0;
        end else if (advance_i) begin
            if (n_last) begin
                n_d = '0;
                if (r_last) begin
                    r_d = '0;
                    m_d = m_q + 1'b1;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end else begin
                n_d = n_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_size_q <= '0;
            n_size_q <= '0;
            m_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
        end else begin
            m_size_q <= m_size_d;
            n_size_q <= n_size_d;
            m_q      <= m_d;
            n_q      <= n_d;
            r_q      <= r_d;
        end
    end

    // Low AddrWidth bits of a product only depend on the low AddrWidth bits
    // of its operands, so doing the arithmetic at AddrWidth is exact.
    always_comb begin
        addr_o = AddrWidth'(m_q) * AddrWidth'(n_size_q) + AddrWidth'(n_q);
    end

    assign r_o         = r_q;
    assign last_frag_o = m_last & r_last & n_last;

endmodule

// File: rtl/c_block_drain.sv
// c_block_drain: reads C blocks (meshRow x meshCol elements per SRAM word)
// and streams the full matrix (M*meshRow x N*meshCol) one element per
// transfer in global row-major order over a valid/ready interface.
// Each row fragment costs READ + CAPTURE + meshCol EMIT cycles.
//
// Ports:
//   clk_i, rst_ni     - clock, asynchronous active-low reset
//   start_i           - start pulse (ignored unless idle)
//   M_size_i/N_size_i - block rows / block columns, registered on start
//   sram_c_addr_o     - block read address (changes only in READ)
//   sram_c_rdata_i    - block word, valid the cycle after the address
//   m_valid_o/m_ready_i/m_data_o/m_last_o - element stream
//   busy_o            - drain in progress (accepted start through DONE)
//   done_o            - one-cycle completion pulse
//   stall_cnt_o       - saturating count of valid-but-not-ready cycles,
//                       present only with C_BLOCK_DRAIN_PERF_EN defined
module c_block_drain
    import c_block_drain_pkg::*;
#(
    parameter int unsigned OutDataWidth  = DefOutDataWidth,
    parameter int unsigned meshRow       = DefMeshRow,
    parameter int unsigned meshCol       = DefMeshCol,
    parameter int unsigned AddrWidth     = DefAddrWidth,
    parameter int unsigned SizeAddrWidth = DefSizeAddrWidth
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    start_i,
    input  logic [SizeAddrWidth-1:0]                M_size_i,
    input  logic [SizeAddrWidth-1:0]                N_size_i,
    output logic [AddrWidth-1:0]                    sram_c_addr_o,
    input  logic [meshRow*meshCol*OutDataWidth-1:0] sram_c_rdata_i,
    output logic                                    m_valid_o,
    input  logic                                    m_ready_i,
    output logic [OutDataWidth-1:0]                 m_data_o,
    output logic                                    m_last_o,
    output logic                                    busy_o,
    output logic                                    done_o
`ifdef C_BLOCK_DRAIN_PERF_EN
    ,
    output logic [31:0]                             stall_cnt_o
`endif
);

    localparam int unsigned RowIdxWidth = idx_width(meshRow);
    localparam int unsigned ColIdxWidth = idx_width(meshCol);

    drain_state_e            state_q, state_d;
    logic [ColIdxWidth-1:0]  col_q, col_d;
    logic [OutDataWidth-1:0] hold_q [meshCol];
    logic [OutDataWidth-1:0] hold_d [meshCol];
    logic [AddrWidth-1:0]    addr_q, addr_d;

    logic                    load;
    logic                    advance;
    logic                    last_frag;
    logic                    size_empty;
    logic                    xfer;
    logic                    col_last;
    logic [RowIdxWidth-1:0]  row_idx;
    logic [AddrWidth-1:0]    blk_addr;
    int unsigned             row_base;

    c_drain_addr_gen #(
        .meshRow       (meshRow),
        .AddrWidth     (AddrWidth),
        .SizeAddrWidth (SizeAddrWidth),
        .RowIdxWidth   (RowIdxWidth)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (load),
        .M_size_i    (M_size_i),
        .N_size_i    (N_size_i),
        .advance_i   (advance),
        .r_o         (row_idx),
        .addr_o      (blk_addr),
        .last_frag_o (last_frag)
    );

    // Emptiness is judged on the live inputs so an empty request reaches
    // DONE on the very next cycle without touching the SRAM.
    assign size_empty = (M_size_i == '0) || (N_size_i == '0);
    assign xfer       = m_valid_o && m_ready_i;
    assign col_last   = (col_q == ColIdxWidth'(meshCol - 1));

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        hold_d   = hold_q;
        addr_d   = addr_q;
        load     = 1'b0;
        advance  = 1'b0;
        row_base = 32'(row_idx) * meshCol;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    col_d   = '0;
                    state_d = size_empty ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                addr_d  = blk_addr;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                for (int unsigned c = 0; c < meshCol; c++) begin
                    hold_d[c] = sram_c_rdata_i[(row_base + c) * OutDataWidth +: OutDataWidth];
                end
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (xfer) begin
                    if (col_last) begin
                        col_d = '0;
                        if (last_frag) begin
                            state_d = ST_DONE;
                        end else begin
                            advance = 1'b1;
                            state_d = ST_READ;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            addr_q  <= '0;
            for (int unsigned c = 0; c < meshCol; c++) begin
                hold_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
        end
    end

    // Address is live during READ and otherwise holds the last block read.
    assign sram_c_addr_o = (state_q == ST_READ) ? blk_addr : addr_q;
    assign m_valid_o     = (state_q == ST_EMIT);
    assign m_data_o      = hold_q[col_q];
    assign m_last_o      = m_valid_o && last_frag && col_last;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);

`ifdef C_BLOCK_DRAIN_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load) begin
            stall_cnt_d = '0;
        end else if (m_valid_o && !m_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
